core_unit_arbiter: RTL and testbench
====================================

// Module: core_unit_arbiter
// PURPOSE
//  Multi-thread successor to the single-thread core datapath. Arbitrates unit requests from
//  N_THREADS hardware threads onto one shared ALU (internal alu instance) and one memory port.
//  Grants are round-robin; one request is in flight at a time. Unlike the single-thread core,
//  the memory port has a valid/ready handshake with variable read latency.
// PARAMETERS
//  N_THREADS  4   number of requesting threads (>=2); thread index width TID_W=$clog2(N_THREADS)
//  WORD_W     32  datapath width; must equal width of word_t
// PORTS
//  clk         in   1               clock, rising edge
//  rst         in   1               reset, asynchronous, active-low (0 = reset)
//  req_valid   in   N_THREADS       thread i has a request; held with payload until rsp_valid[i]
//  req_sel     in   N x unit_sel_t  per-thread unit select (UNIT_SEL_ALU / UNIT_SEL_MEM / other)
//  req_ctrl    in   N x WORD_W      per-thread unit control (ALU: alu_ctrl_t; MEM: bit0 = write)
//  req_in0     in   N x WORD_W      operand 0 (MEM: address)
//  req_in1     in   N x WORD_W      operand 1 (MEM: write data)
//  rsp_valid   out  N_THREADS       one-cycle pulse, one-hot: request of thread i complete
//  rsp_data    out  WORD_W          result for the pulsing thread (registered)
//  mem_valid   out  1               memory request valid
//  mem_ready   in   1               memory accepts request when mem_valid & mem_ready
//  mem_addr    out  WORD_W          captured in0
//  mem_din     out  WORD_W          captured in1
//  mem_we      out  1               captured ctrl[0]
//  mem_rvalid  in   1               read data valid (reads only)
//  mem_rdata   in   WORD_W          read data
// BEHAVIOUR
//  Reset: state IDLE, rr pointer 0, rsp_valid=0, rsp_data=0, mem_valid=0, mem_addr/din/we=0.
//   Asserting rst mid-operation aborts the in-flight request; no rsp_valid issued for it.
//  Arbitration (IDLE): candidates = req_valid & ~rsp_valid (thread just answered is masked
//   that cycle). Grant first candidate at or after rr pointer, wrapping N-1 -> 0. On grant:
//   capture tid, sel, ctrl, in0, in1; rr pointer <= tid+1 (mod N). No candidate: stay IDLE.
//  FSM: IDLE, EXEC, MEM_REQ, MEM_WAIT, RESP.
//   IDLE -> EXEC if captured sel != UNIT_SEL_MEM; IDLE -> MEM_REQ if sel == UNIT_SEL_MEM.
//   EXEC: result = alu(ctrl, in0, in1) if ALU, else 0; register into rsp_data; -> RESP.
//   MEM_REQ: mem_valid=1 (registered, high from first MEM_REQ cycle); addr/din/we stable until
//    handshake. On mem_valid&mem_ready: mem_valid<=0; write -> RESP with rsp_data<=0;
//    read -> MEM_WAIT.
//   MEM_WAIT: on mem_rvalid, rsp_data<=mem_rdata, -> RESP. mem_rvalid outside MEM_WAIT ignored.
//   RESP: rsp_valid[tid]=1 for exactly this cycle; also acts as IDLE (may grant in same cycle,
//    with tid masked) -> EXEC/MEM_REQ on grant, else IDLE.
//  Latency (grant cycle T): ALU/other -> rsp_valid at T+2. Write -> RESP one cycle after
//   handshake. Read -> RESP one cycle after mem_rvalid.
//  Back-to-back ALU requests: one grant every 2 cycles.
//  Payload changes on req_* while granted have no effect (captured at grant).
//  Width: ALU result truncated to WORD_W; no flags.
// TESTING
//  1 rst release; thread 1 ALU add, in0=3, in1=4 at T -> rsp_valid=0010 at T+2, rsp_data=7;
//    no other rsp_valid bits.
//  2 all 4 threads ALU, req_valid=1111 from first post-reset cycle -> responses to threads
//    0,1,2,3 in that order, 2 cycles apart.
//  3 thread 2 MEM write, addr=0x100, din=0xA5, mem_ready low 3 cycles -> mem_valid high 4
//    cycles, addr/din/we stable; rsp_valid[2] one cycle after handshake, rsp_data=0.
//  4 thread 3 MEM read, addr=0x40; mem_rvalid 5 cycles after handshake, rdata=0xDEADBEEF ->
//    rsp_valid[3] next cycle, rsp_data=0xDEADBEEF.
//  5 thread 0 keeps req_valid high after its rsp, thread 1 also requesting -> thread 1
//    granted next; thread 0 not regranted in its rsp cycle.
//  6 rst low during MEM_WAIT -> mem_valid, rsp_valid, rsp_data 0 immediately; late
//    mem_rvalid ignored; after release, first grant goes to thread 0.

Source files
------------

// File: rtl/core_unit_arbiter.sv
// Round-robin arbiter that shares one ALU and one valid/ready memory port between N hardware threads.
// Only one request is in flight at a time; the RESP state doubles as an arbitration slot.
package core_unit_pkg;
  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    UNIT_SEL_ALU  = 2'd0,
    UNIT_SEL_MEM  = 2'd1,
    UNIT_SEL_NONE = 2'd2,
    UNIT_SEL_RSVD = 2'd3
  } unit_sel_t;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SLL   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_SLT   = 4'd8,
    ALU_SLTU  = 4'd9,
    ALU_PASS0 = 4'd10,
    ALU_PASS1 = 4'd11
  } alu_ctrl_t;
endpackage

module core_unit_alu
  import core_unit_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic [WORD_W-1:0] ctrl,
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  output logic [WORD_W-1:0] y
);
  localparam int SH_W = $clog2(WORD_W);

  alu_ctrl_t op;
  logic      legal;

  // Control words with any bit set above the opcode field are treated as undefined and yield 0.
  always_comb begin
    op    = alu_ctrl_t'(ctrl[3:0]);
    legal = (ctrl[WORD_W-1:4] == '0);
    y     = '0;
    if (legal) begin
      case (op)
        ALU_ADD:   y = a + b;
        ALU_SUB:   y = a - b;
        ALU_AND:   y = a & b;
        ALU_OR:    y = a | b;
        ALU_XOR:   y = a ^ b;
        ALU_SLL:   y = a << b[SH_W-1:0];
        ALU_SRL:   y = a >> b[SH_W-1:0];
        ALU_SRA:   y = $signed(a) >>> b[SH_W-1:0];
        ALU_SLT:   y = {{(WORD_W-1){1'b0}}, ($signed(a) < $signed(b))};
        ALU_SLTU:  y = {{(WORD_W-1){1'b0}}, (a < b)};
        ALU_PASS0: y = a;
        ALU_PASS1: y = b;
        default:   y = '0;
      endcase
    end
  end
endmodule

module core_unit_arbiter
  import core_unit_pkg::*;
#(
  parameter int N_THREADS = 4,
  parameter int WORD_W    = 32
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [N_THREADS-1:0]               req_valid,
  input  unit_sel_t [N_THREADS-1:0]          req_sel,
  input  logic [N_THREADS-1:0][WORD_W-1:0]   req_ctrl,
  input  logic [N_THREADS-1:0][WORD_W-1:0]   req_in0,
  input  logic [N_THREADS-1:0][WORD_W-1:0]   req_in1,
  output logic [N_THREADS-1:0]               rsp_valid,
  output logic [WORD_W-1:0]                  rsp_data,
  output logic                               mem_valid,
  input  logic                               mem_ready,
  output logic [WORD_W-1:0]                  mem_addr,
  output logic [WORD_W-1:0]                  mem_din,
  output logic                               mem_we,
  input  logic                               mem_rvalid,
  input  logic [WORD_W-1:0]                  mem_rdata
);
  localparam int TID_W = $clog2(N_THREADS);

  typedef enum logic [2:0] {
    IDLE,
    EXEC,
    MEM_REQ,
    MEM_WAIT,
    RESP
  } state_t;

  state_t              state_q, state_d;
  logic [TID_W-1:0]    rr_q, tid_q, grant_idx, rr_next;
  logic [TID_W:0]      idx;
  logic                grant_found, can_grant, grant_mem, mem_hs;
  unit_sel_t           sel_q;
  logic [WORD_W-1:0]   ctrl_q, in0_q, in1_q, alu_y;
  logic [N_THREADS-1:0] cand;

  assign cand      = req_valid & ~rsp_valid;
  assign can_grant = (state_q == IDLE) || (state_q == RESP);
  assign grant_mem = (req_sel[grant_idx] == UNIT_SEL_MEM);
  assign mem_hs    = mem_valid & mem_ready;
  assign rr_next   = (grant_idx == TID_W'(N_THREADS - 1)) ? '0 : grant_idx + 1'b1;

  assign mem_addr = in0_q;
  assign mem_din  = in1_q;
  assign mem_we   = ctrl_q[0];

  // Round-robin search: first candidate at or after the pointer, wrapping past the last thread.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = '0;
    for (int i = 0; i < N_THREADS; i++) begin
      idx = {1'b0, rr_q} + (TID_W + 1)'(i);
      if (idx >= (TID_W + 1)'(N_THREADS)) begin
        idx = idx - (TID_W + 1)'(N_THREADS);
      end
      if (!grant_found && cand[idx[TID_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = idx[TID_W-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, RESP: begin
        if (grant_found) begin
          state_d = grant_mem ? MEM_REQ : EXEC;
        end else begin
          state_d = IDLE;
        end
      end
      EXEC:     state_d = RESP;
      MEM_REQ:  if (mem_hs) state_d = mem_we ? RESP : MEM_WAIT;
      MEM_WAIT: if (mem_rvalid) state_d = RESP;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Payload is frozen at grant so requesters may change req_* freely while their request runs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_q   <= '0;
      tid_q  <= '0;
      sel_q  <= UNIT_SEL_ALU;
      ctrl_q <= '0;
      in0_q  <= '0;
      in1_q  <= '0;
    end else if (can_grant && grant_found) begin
      rr_q   <= rr_next;
      tid_q  <= grant_idx;
      sel_q  <= req_sel[grant_idx];
      ctrl_q <= req_ctrl[grant_idx];
      in0_q  <= req_in0[grant_idx];
      in1_q  <= req_in1[grant_idx];
    end
  end

  core_unit_alu #(.WORD_W(WORD_W)) u_alu (
    .ctrl (ctrl_q),
    .a    (in0_q),
    .b    (in1_q),
    .y    (alu_y)
  );

  // rsp_valid pulses only on entry to RESP, which can never follow RESP directly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
      mem_valid <= 1'b0;
    end else begin
      rsp_valid <= (state_d == RESP) ? (N_THREADS'(1) << tid_q) : '0;
      if (can_grant && grant_found && grant_mem) begin
        mem_valid <= 1'b1;
      end else if (state_q == MEM_REQ && mem_hs) begin
        mem_valid <= 1'b0;
      end
      case (state_q)
        EXEC:     rsp_data <= (sel_q == UNIT_SEL_ALU) ? alu_y : '0;
        MEM_REQ:  if (mem_hs && mem_we) rsp_data <= '0;
        MEM_WAIT: if (mem_rvalid) rsp_data <= mem_rdata;
        default:  rsp_data <= rsp_data;
      endcase
    end
  end
endmodule

// File: tb/tb_core_unit_arbiter.sv
// Directed bench for core_unit_arbiter: stimulus pushes expected (thread, data, cycle) into a
// scoreboard queue and a negedge monitor pops and compares on every rsp_valid pulse.
module tb_core_unit_arbiter;
  import core_unit_pkg::*;

  localparam int N = 4;
  localparam int W = 32;

  typedef struct {
    int          tid;
    logic [W-1:0] data;
    int          cyc;
  } exp_t;

  logic                 clk;
  logic                 rst;
  logic [N-1:0]         req_valid;
  unit_sel_t [N-1:0]    req_sel;
  logic [N-1:0][W-1:0]  req_ctrl, req_in0, req_in1;
  logic [N-1:0]         rsp_valid;
  logic [W-1:0]         rsp_data;
  logic                 mem_valid, mem_ready, mem_we, mem_rvalid;
  logic [W-1:0]         mem_addr, mem_din, mem_rdata;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  core_unit_arbiter #(.N_THREADS(N), .WORD_W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_sel    (req_sel),
    .req_ctrl   (req_ctrl),
    .req_in0    (req_in0),
    .req_in1    (req_in1),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .mem_we     (mem_we),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input int tid, input unit_sel_t sel, input logic [W-1:0] ctrl,
                                input logic [W-1:0] in0, input logic [W-1:0] in1);
    req_sel[tid]   = sel;
    req_ctrl[tid]  = ctrl;
    req_in0[tid]   = in0;
    req_in1[tid]   = in1;
    req_valid[tid] = 1'b1;
  endtask

  task automatic expect_rsp(input int tid, input logic [W-1:0] data, input int at_cyc);
    exp_t e;
    e.tid  = tid;
    e.data = data;
    e.cyc  = at_cyc;
    exp_q.push_back(e);
  endtask

  // Drops each request once its response is seen; bounded so a stuck DUT still reaches the summary.
  task automatic run_until_idle(input int max_cycles);
    int n;
    n = 0;
    while (1) begin
      req_valid = req_valid & ~rsp_valid;
      if (req_valid == '0 && exp_q.size() == 0) break;
      if (n >= max_cycles) begin
        check_output("idle_timeout", 64'(exp_q.size()), 64'd0);
        req_valid = '0;
        exp_q.delete();
        break;
      end
      tick();
      n++;
    end
  endtask

  // Monitor: any rsp pulse must match the oldest expectation exactly in thread, data and cycle.
  always @(negedge clk) begin
    exp_t e;
    if (rsp_valid != '0) begin
      if (exp_q.size() == 0) begin
        check_output("unexpected_rsp", 64'(rsp_valid), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check_output("rsp_onehot", 64'(rsp_valid), 64'(N'(1) << e.tid));
        check_output("rsp_data", 64'(rsp_data), 64'(e.data));
        check_output("rsp_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int k;
    rst        = 1'b0;
    req_valid  = '0;
    req_sel    = {N{UNIT_SEL_ALU}};
    req_ctrl   = '0;
    req_in0    = '0;
    req_in1    = '0;
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    tick();
    tick();
    check_output("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    check_output("reset_rsp_data", 64'(rsp_data), 64'd0);
    check_output("reset_mem_valid", 64'(mem_valid), 64'd0);
    check_output("reset_mem_addr", 64'(mem_addr), 64'd0);
    check_output("reset_mem_din", 64'(mem_din), 64'd0);
    check_output("reset_mem_we", 64'(mem_we), 64'd0);
    rst = 1'b1;
    tick();

    $display("[TB] test 1: single ALU add, payload change after grant");
    k = cyc;
    apply_stimulus(1, UNIT_SEL_ALU, W'(ALU_ADD), 32'd3, 32'd4);
    expect_rsp(1, 32'd7, k + 2);
    tick();
    req_in0[1] = 32'd100;
    run_until_idle(20);

    $display("[TB] test 1b: non-ALU, non-MEM select returns zero");
    k = cyc;
    apply_stimulus(0, UNIT_SEL_NONE, W'(ALU_ADD), 32'd3, 32'd4);
    expect_rsp(0, 32'd0, k + 2);
    run_until_idle(20);

    $display("[TB] test 2: four ALU requests from first post-reset cycle");
    rst = 1'b0;
    apply_stimulus(0, UNIT_SEL_ALU, W'(ALU_ADD), 32'h10, 32'h20);
    apply_stimulus(1, UNIT_SEL_ALU, W'(ALU_SUB), 32'd5, 32'd7);
    apply_stimulus(2, UNIT_SEL_ALU, W'(ALU_XOR), 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    apply_stimulus(3, UNIT_SEL_ALU, W'(ALU_SLL), 32'd1, 32'd4);
    tick();
    rst = 1'b1;
    k = cyc;
    expect_rsp(0, 32'h30, k + 2);
    expect_rsp(1, 32'hFFFF_FFFE, k + 4);
    expect_rsp(2, 32'hFF00_FF00, k + 6);
    expect_rsp(3, 32'h10, k + 8);
    run_until_idle(30);

    $display("[TB] test 3: memory write with back-pressure");
    k = cyc;
    mem_ready = 1'b0;
    apply_stimulus(2, UNIT_SEL_MEM, 32'd1, 32'h100, 32'hA5);
    expect_rsp(2, 32'd0, k + 5);
    for (int i = 1; i <= 4; i++) begin
      tick();
      req_in0[2] = 32'h999;
      check_output("wr_mem_valid", 64'(mem_valid), 64'd1);
      check_output("wr_mem_addr", 64'(mem_addr), 64'h100);
      check_output("wr_mem_din", 64'(mem_din), 64'hA5);
      check_output("wr_mem_we", 64'(mem_we), 64'd1);
      if (i == 4) mem_ready = 1'b1;
    end
    tick();
    mem_ready = 1'b0;
    check_output("wr_mem_valid_drop", 64'(mem_valid), 64'd0);
    run_until_idle(20);

    $display("[TB] test 4: memory read with 5-cycle latency");
    k = cyc;
    mem_ready = 1'b1;
    apply_stimulus(3, UNIT_SEL_MEM, 32'd0, 32'h40, 32'd0);
    expect_rsp(3, 32'hDEAD_BEEF, k + 7);
    tick();
    check_output("rd_mem_valid", 64'(mem_valid), 64'd1);
    check_output("rd_mem_addr", 64'(mem_addr), 64'h40);
    check_output("rd_mem_we", 64'(mem_we), 64'd0);
    tick();
    mem_ready = 1'b0;
    check_output("rd_mem_valid_drop", 64'(mem_valid), 64'd0);
    repeat (4) tick();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hDEAD_BEEF;
    tick();
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    run_until_idle(20);

    $display("[TB] test 5: answered thread is masked, other thread granted");
    k = cyc;
    apply_stimulus(0, UNIT_SEL_ALU, W'(ALU_ADD), 32'd1, 32'd1);
    expect_rsp(0, 32'd2, k + 2);
    expect_rsp(1, 32'd4, k + 4);
    expect_rsp(0, 32'd2, k + 6);
    tick();
    apply_stimulus(1, UNIT_SEL_ALU, W'(ALU_ADD), 32'd2, 32'd2);
    repeat (3) tick();
    req_valid[1] = 1'b0;
    repeat (2) tick();
    req_valid[0] = 1'b0;
    repeat (3) tick();

    $display("[TB] test 5b: lone thread held high is not regranted in its RESP cycle");
    k = cyc;
    apply_stimulus(0, UNIT_SEL_ALU, W'(ALU_ADD), 32'd5, 32'd5);
    expect_rsp(0, 32'd10, k + 2);
    expect_rsp(0, 32'd10, k + 5);
    repeat (5) tick();
    req_valid[0] = 1'b0;
    repeat (3) tick();

    $display("[TB] test 6: reset during MEM_WAIT");
    mem_ready = 1'b1;
    apply_stimulus(2, UNIT_SEL_MEM, 32'd0, 32'h80, 32'd0);
    repeat (3) tick();
    mem_ready = 1'b0;
    rst = 1'b0;
    req_valid[2] = 1'b0;
    #1;
    check_output("rst6_mem_valid", 64'(mem_valid), 64'd0);
    check_output("rst6_rsp_valid", 64'(rsp_valid), 64'd0);
    check_output("rst6_rsp_data", 64'(rsp_data), 64'd0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h1234_5678;
    tick();
    rst = 1'b1;
    tick();
    mem_rvalid = 1'b0;
    tick();
    k = cyc;
    apply_stimulus(3, UNIT_SEL_ALU, W'(ALU_ADD), 32'd3, 32'd4);
    apply_stimulus(0, UNIT_SEL_ALU, W'(ALU_ADD), 32'd1, 32'd2);
    expect_rsp(0, 32'd3, k + 2);
    expect_rsp(3, 32'd7, k + 4);
    run_until_idle(20);

    repeat (3) tick();
    check_output("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
